// File: rtl/counter_sweep_ctrl.sv
// Sweep controller: drives an external up/down counter between two bounds.
// Each bound is held for a programmable dwell. Runs one round trip or repeats.
module counter_sweep_ctrl #(
  parameter int n  = 4,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          abort,
  input  logic          mode,
  input  logic [n-1:0]  lo,
  input  logic [n-1:0]  hi,
  input  logic [DW-1:0] dwell,
  input  logic [n-1:0]  count,
  output logic          up,
  output logic          enable,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [7:0]    sweeps,
  output logic [2:0]    state_dbg
);

  // Control semantics: start is a level sampled only in IDLE; it is accepted
  // when lo<hi and rejected with a one-cycle err pulse otherwise. abort
  // overrides everything, including a start in the same cycle.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEEK    = 3'd1,
    RISE    = 3'd2,
    HOLD_HI = 3'd3,
    FALL    = 3'd4,
    HOLD_LO = 3'd5
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [n-1:0]  r_lo;
  logic [n-1:0]  r_hi;
  logic [DW-1:0] r_dwell;
  logic          r_mode;
  logic [DW-1:0] r_timer;
  logic [7:0]    r_sweeps;
  logic          r_done;
  logic          r_err;

  logic w_enable;
  logic w_up;
  logic w_capture;
  logic w_reject;
  logic w_timer_load;
  logic w_timer_dec;
  logic w_sweep_inc;
  logic w_done_set;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // up/enable come straight from count so the counter stops exactly on a bound.
  always_comb begin
    w_next_state = r_state;
    w_enable     = 1'b0;
    w_up         = 1'b0;
    w_capture    = 1'b0;
    w_reject     = 1'b0;
    w_timer_load = 1'b0;
    w_timer_dec  = 1'b0;
    w_sweep_inc  = 1'b0;
    w_done_set   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (lo < hi) begin
            w_capture    = 1'b1;
            w_next_state = SEEK;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      SEEK: begin
        if (count != r_lo) begin
          w_enable = 1'b1;
          w_up     = (count < r_lo);
        end else begin
          w_next_state = RISE;
        end
      end
      RISE: begin
        if (count != r_hi) begin
          w_enable = 1'b1;
          w_up     = 1'b1;
        end else begin
          w_timer_load = 1'b1;
          w_next_state = HOLD_HI;
        end
      end
      HOLD_HI: begin
        if (r_timer == '0) begin
          w_next_state = FALL;
        end else begin
          w_timer_dec = 1'b1;
        end
      end
      FALL: begin
        if (count != r_lo) begin
          w_enable = 1'b1;
          w_up     = 1'b0;
        end else begin
          w_timer_load = 1'b1;
          w_next_state = HOLD_LO;
        end
      end
      HOLD_LO: begin
        if (r_timer == '0) begin
          w_sweep_inc = 1'b1;
          if (r_mode) begin
            w_next_state = RISE;
          end else begin
            w_done_set   = 1'b1;
            w_next_state = IDLE;
          end
        end else begin
          w_timer_dec = 1'b1;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase

    if (abort) begin
      w_next_state = IDLE;
      w_enable     = 1'b0;
      w_up         = 1'b0;
      w_capture    = 1'b0;
      w_reject     = 1'b0;
      w_timer_load = 1'b0;
      w_timer_dec  = 1'b0;
      w_sweep_inc  = 1'b0;
      w_done_set   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lo    <= '0;
      r_hi    <= '0;
      r_dwell <= '0;
      r_mode  <= 1'b0;
    end else if (w_capture) begin
      r_lo    <= lo;
      r_hi    <= hi;
      r_dwell <= dwell;
      r_mode  <= mode;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_timer <= '0;
    end else if (w_timer_load) begin
      r_timer <= r_dwell;
    end else if (w_timer_dec) begin
      r_timer <= r_timer - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sweeps <= '0;
    end else if (w_capture) begin
      r_sweeps <= '0;
    end else if (w_sweep_inc && (r_sweeps != 8'hFF)) begin
      r_sweeps <= r_sweeps + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= w_done_set;
      r_err  <= w_reject;
    end
  end

  assign up        = w_up;
  assign enable    = w_enable;
  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign err       = r_err;
  assign sweeps    = r_sweeps;
  assign state_dbg = r_state;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Directed bench for counter_sweep_ctrl with a behavioural up/down counter
// closing the loop on count.
module tb_counter_sweep_ctrl;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic       abort;
  logic       mode;
  logic [3:0] lo;
  logic [3:0] hi;
  logic [3:0] dwell;
  logic [3:0] cnt;
  logic       up;
  logic       enable;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] sweeps;
  logic [2:0] state_dbg;

  logic       load_en;
  logic [3:0] load_val;

  int n_checks;
  int n_pass;
  int up_cyc, dn_cyc, busy_cyc, done_cnt, err_cnt;
  logic [3:0] cmin, cmax;

  counter_sweep_ctrl #(.n(4), .DW(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .mode      (mode),
    .lo        (lo),
    .hi        (hi),
    .dwell     (dwell),
    .count     (cnt),
    .up        (up),
    .enable    (enable),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .sweeps    (sweeps),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load_en) cnt <= load_val;
    else if (enable) cnt <= up ? cnt + 4'd1 : cnt - 4'd1;
  end

  task automatic load_count(input logic [3:0] v);
    load_en = 1'b1; load_val = v;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic do_start(input logic [3:0] l, input logic [3:0] h,
                          input logic [3:0] d, input logic m);
    lo = l; hi = h; dwell = d; mode = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clear_track();
    up_cyc = 0; dn_cyc = 0; busy_cyc = 0; done_cnt = 0; err_cnt = 0;
    cmin = cnt; cmax = cnt;
  endtask

  task automatic sample_track();
    if (busy) busy_cyc++;
    if (enable && up) up_cyc++;
    if (enable && !up) dn_cyc++;
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (cnt < cmin) cmin = cnt;
    if (cnt > cmax) cmax = cnt;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 0; abort = 0; mode = 0; lo = 0; hi = 0; dwell = 0;
    load_en = 1'b0; load_val = 0;
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (enable !== 1'b0 || up !== 1'b0) $display("FAIL reset_en_up: got %b%b expected 00", enable, up); else n_pass++;
    n_checks++; if (done !== 1'b0 || err !== 1'b0) $display("FAIL reset_done_err: got %b%b expected 00", done, err); else n_pass++;
    n_checks++; if (sweeps !== 8'd0) $display("FAIL reset_sweeps: got %0d expected 0", sweeps); else n_pass++;
    n_checks++; if (state_dbg !== 3'd0) $display("FAIL reset_state: got %0d expected 0", state_dbg); else n_pass++;
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    load_count(4'd0);
  endtask

  task automatic test_single_sweep();
    load_count(4'd0);
    do_start(4'd3, 4'd6, 4'd2, 1'b0);
    clear_track();
    for (int i = 0; i < 40; i++) begin
      sample_track();
      if (i == 5) begin lo = 4'd0; hi = 4'd15; dwell = 4'd15; start = 1'b1; end
      if (i == 6) start = 1'b0;
      @(negedge clk);
    end
    n_checks++; if (up_cyc != 6) $display("FAIL single_up_steps: got %0d expected 6", up_cyc); else n_pass++;
    n_checks++; if (dn_cyc != 3) $display("FAIL single_down_steps: got %0d expected 3", dn_cyc); else n_pass++;
    n_checks++; if (busy_cyc != 18) $display("FAIL single_busy_cycles: got %0d expected 18", busy_cyc); else n_pass++;
    n_checks++; if (done_cnt != 1) $display("FAIL single_done_pulses: got %0d expected 1", done_cnt); else n_pass++;
    n_checks++; if (sweeps !== 8'd1) $display("FAIL single_sweeps: got %0d expected 1", sweeps); else n_pass++;
    n_checks++; if (cmin != 0 || cmax != 6) $display("FAIL single_range: got %0d..%0d expected 0..6", cmin, cmax); else n_pass++;
    n_checks++; if (err_cnt != 0) $display("FAIL single_no_err: got %0d expected 0", err_cnt); else n_pass++;
  endtask

  task automatic test_seek_down();
    load_count(4'd12);
    do_start(4'd5, 4'd9, 4'd0, 1'b0);
    clear_track();
    for (int i = 0; i < 40; i++) begin
      sample_track();
      @(negedge clk);
    end
    n_checks++; if (dn_cyc != 11) $display("FAIL seek_down_steps: got %0d expected 11", dn_cyc); else n_pass++;
    n_checks++; if (up_cyc != 4) $display("FAIL seek_up_steps: got %0d expected 4", up_cyc); else n_pass++;
    n_checks++; if (busy_cyc != 20) $display("FAIL seek_busy_cycles: got %0d expected 20", busy_cyc); else n_pass++;
    n_checks++; if (cmin != 5 || cmax != 12) $display("FAIL seek_range: got %0d..%0d expected 5..12", cmin, cmax); else n_pass++;
    n_checks++; if (done_cnt != 1) $display("FAIL seek_done_pulses: got %0d expected 1", done_cnt); else n_pass++;
  endtask

  task automatic test_err();
    do_start(4'd7, 4'd7, 4'd3, 1'b1);
    n_checks++; if (err !== 1'b1) $display("FAIL err_pulse: got %b expected 1", err); else n_pass++;
    n_checks++; if (busy !== 1'b0 || enable !== 1'b0) $display("FAIL err_idle: got busy=%b en=%b expected 0 0", busy, enable); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL err_no_done: got %b expected 0", done); else n_pass++;
    @(negedge clk);
    n_checks++; if (err !== 1'b0) $display("FAIL err_width: got %b expected 0", err); else n_pass++;
    n_checks++; if (sweeps !== 8'd1) $display("FAIL err_no_capture: got %0d expected 1", sweeps); else n_pass++;
  endtask

  task automatic test_abort_same_cycle();
    abort = 1'b1;
    do_start(4'd7, 4'd3, 4'd0, 1'b0);
    n_checks++; if (err !== 1'b0) $display("FAIL abort_start_err: got %b expected 0", err); else n_pass++;
    do_start(4'd1, 4'd5, 4'd0, 1'b0);
    abort = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("FAIL abort_start_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (sweeps !== 8'd1) $display("FAIL abort_start_sweeps: got %0d expected 1", sweeps); else n_pass++;
  endtask

  task automatic test_abort();
    bit found;
    found = 1'b0;
    load_count(4'd0);
    do_start(4'd2, 4'd9, 4'd1, 1'b0);
    for (int i = 0; i < 30; i++) begin
      if (cnt == 4'd5) begin found = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++; if (!found || enable !== 1'b1) $display("FAIL abort_reach5: got found=%0d en=%b expected 1 1", found, enable); else n_pass++;
    abort = 1'b1;
    #1;
    n_checks++; if (enable !== 1'b0) $display("FAIL abort_comb_en: got %b expected 0", enable); else n_pass++;
    @(negedge clk);
    abort = 1'b0;
    n_checks++; if (busy !== 1'b0 || cnt !== 4'd5) $display("FAIL abort_idle: got busy=%b cnt=%0d expected 0 5", busy, cnt); else n_pass++;
    @(negedge clk);
    n_checks++; if (done !== 1'b0 || cnt !== 4'd5) $display("FAIL abort_no_done: got done=%b cnt=%0d expected 0 5", done, cnt); else n_pass++;
    do_start(4'd5, 4'd6, 4'd0, 1'b0);
    n_checks++; if (busy !== 1'b1) $display("FAIL abort_restart: got %b expected 1", busy); else n_pass++;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (done) begin found = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++; if (!found) $display("FAIL abort_restart_done: got 0 expected 1"); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_continuous();
    load_count(4'd2);
    do_start(4'd2, 4'd4, 4'd0, 1'b1);
    clear_track();
    for (int k = 0; k <= 2100; k++) begin
      sample_track();
      if (k == 600) begin
        n_checks++; if (sweeps !== 8'd74) $display("FAIL cont_sweeps_600: got %0d expected 74", sweeps); else n_pass++;
      end
      @(negedge clk);
    end
    n_checks++; if (sweeps !== 8'd255) $display("FAIL cont_saturate: got %0d expected 255", sweeps); else n_pass++;
    n_checks++; if (cmin != 2 || cmax != 4) $display("FAIL cont_range: got %0d..%0d expected 2..4", cmin, cmax); else n_pass++;
    n_checks++; if (done_cnt != 0) $display("FAIL cont_no_done: got %0d expected 0", done_cnt); else n_pass++;
    n_checks++; if (busy_cyc != 2101) $display("FAIL cont_busy: got %0d expected 2101", busy_cyc); else n_pass++;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++; if (busy !== 1'b0 || sweeps !== 8'd255) $display("FAIL cont_abort_keep: got busy=%b sweeps=%0d expected 0 255", busy, sweeps); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit found;
    load_count(4'd1);
    do_start(4'd1, 4'd3, 4'd0, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (sweeps == 8'd1 && enable && !up) begin found = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++; if (!found) $display("FAIL rmid_reach_fall: got 0 expected 1"); else n_pass++;
    reset_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || enable !== 1'b0 || up !== 1'b0) $display("FAIL rmid_outputs: got busy=%b en=%b up=%b expected 0 0 0", busy, enable, up); else n_pass++;
    n_checks++; if (sweeps !== 8'd0) $display("FAIL rmid_sweeps: got %0d expected 0", sweeps); else n_pass++;
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL rmid_no_done: got done=%b busy=%b expected 0 0", done, busy); else n_pass++;
    do_start(4'd2, 4'd3, 4'd0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin found = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++; if (!found || sweeps !== 8'd1) $display("FAIL rmid_restart: got done=%0d sweeps=%0d expected 1 1", found, sweeps); else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_single_sweep();
    test_seek_down();
    test_err();
    test_abort_same_cycle();
    test_abort();
    test_continuous();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
